// File: rtl/freq_meter_pkg.sv
// Shared types and helpers for the frequency/period meter.
package freq_meter_pkg;

    typedef enum logic [1:0] {
        ARM,
        MEASURE,
        TIMEOUT
    } per_state_t;

    localparam int unsigned SYNC_STAGES = 2;

    // Increment v, holding at the all-ones value of a width-bit field.
    function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned width);
        logic [63:0] max_v;
        max_v = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        return (v >= max_v) ? max_v : v + 64'd1;
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer for an async pin followed by a rising-edge detector.
module edge_sync
    import freq_meter_pkg::*;
(
    input  logic clk_50mhz,
    input  logic rst_50mhz,
    input  logic sig_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;

    always_ff @(posedge clk_50mhz) begin
        if (rst_50mhz) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            dly_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~dly_q;

endmodule

// File: rtl/freq_meter.sv
// Frequency (edges per gate window) and period (cycles between rises) meter
// with loss-of-signal flag.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = 50000000,
    parameter int unsigned GATE_W      = 26,
    parameter int unsigned FREQ_W      = 26,
    parameter int unsigned PER_W       = 32
) (
    input  logic              clk_50mhz,
    input  logic              rst_50mhz,
    input  logic              sig_in,
    output logic [FREQ_W-1:0] freq_hz,
    output logic              freq_valid,
    output logic [PER_W-1:0]  period_cycles,
    output logic              period_valid,
    output logic              no_signal
);

    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [PER_W-1:0]  PER_MAX   = '1;
    localparam logic [PER_W-1:0]  PER_ONE   = PER_W'(1);

    logic              rise;
    logic [GATE_W-1:0] gate_cnt;
    logic [FREQ_W-1:0] edge_cnt;
    logic [FREQ_W-1:0] edge_inc;
    logic              gate_last;

    per_state_t        state_q, state_d;
    logic [PER_W-1:0]  per_cnt_q, per_cnt_d;
    logic [PER_W-1:0]  period_d;
    logic              period_valid_d;
    logic              no_signal_d;

    edge_sync u_edge_sync (
        .clk_50mhz (clk_50mhz),
        .rst_50mhz (rst_50mhz),
        .sig_in    (sig_in),
        .rise      (rise)
    );

    assign gate_last = (gate_cnt == GATE_LAST);
    assign edge_inc  = FREQ_W'(sat_inc(64'(edge_cnt), FREQ_W));

    // A rise on the terminal cycle is folded into the closing window.
    always_ff @(posedge clk_50mhz) begin
        if (rst_50mhz) begin
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            freq_hz    <= '0;
            freq_valid <= 1'b0;
        end else begin
            freq_valid <= gate_last;
            if (gate_last) begin
                gate_cnt <= '0;
                edge_cnt <= '0;
                freq_hz  <= rise ? edge_inc : edge_cnt;
            end else begin
                gate_cnt <= gate_cnt + 1'b1;
                if (rise) begin
                    edge_cnt <= edge_inc;
                end
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        per_cnt_d      = per_cnt_q;
        period_d       = period_cycles;
        period_valid_d = 1'b0;
        no_signal_d    = no_signal;
        case (state_q)
            ARM: begin
                if (rise) begin
                    per_cnt_d = PER_ONE;
                    state_d   = MEASURE;
                end
            end
            MEASURE: begin
                // Rise takes priority, so a rise at the limit still measures PER_MAX.
                if (rise) begin
                    period_d       = per_cnt_q;
                    period_valid_d = 1'b1;
                    per_cnt_d      = PER_ONE;
                    no_signal_d    = 1'b0;
                end else if (per_cnt_q == PER_MAX) begin
                    no_signal_d = 1'b1;
                    state_d     = TIMEOUT;
                end else begin
                    per_cnt_d = per_cnt_q + 1'b1;
                end
            end
            TIMEOUT: begin
                if (rise) begin
                    per_cnt_d = PER_ONE;
                    state_d   = MEASURE;
                end
            end
            default: state_d = ARM;
        endcase
    end

    always_ff @(posedge clk_50mhz) begin
        if (rst_50mhz) begin
            state_q       <= ARM;
            per_cnt_q     <= '0;
            period_cycles <= '0;
            period_valid  <= 1'b0;
            no_signal     <= 1'b0;
        end else begin
            state_q       <= state_d;
            per_cnt_q     <= per_cnt_d;
            period_cycles <= period_d;
            period_valid  <= period_valid_d;
            no_signal     <= no_signal_d;
        end
    end

endmodule

// File: tb/tb_freq_meter.sv
// Scoreboard bench for freq_meter: a gap/window reference model feeds expected
// results into queues that a negedge monitor pops on each valid pulse.
module tb_freq_meter;

    localparam int G    = 1000;
    localparam int FW   = 4;
    localparam int PW   = 8;
    localparam int FMAX = (1 << FW) - 1;
    localparam int PMAX = (1 << PW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sig = 1'b0;
    logic [FW-1:0] freq_hz;
    logic          freq_valid;
    logic [PW-1:0] period_cycles;
    logic          period_valid;
    logic          no_signal;

    typedef struct {
        int idx;
        int val;
    } exp_t;

    exp_t fq[$];
    exp_t pq[$];
    exp_t e;
    bit   lvl[$];
    int   k;
    int   win_cnt;
    int   prev_rise;
    bit   have_prev;
    bit   ns_exp;
    bit   in_rst;
    bit   r_m;
    int   checks = 0;
    int   passed = 0;

    freq_meter #(
        .GATE_CYCLES (G),
        .GATE_W      (10),
        .FREQ_W      (FW),
        .PER_W       (PW)
    ) dut (
        .clk_50mhz     (clk),
        .rst_50mhz     (rst),
        .sig_in        (sig),
        .freq_hz       (freq_hz),
        .freq_valid    (freq_valid),
        .period_cycles (period_cycles),
        .period_valid  (period_valid),
        .no_signal     (no_signal)
    );

    always #10 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: a level sampled at edge j is seen as a rise at edge j+2;
    // frequency = rises per G-edge window; period = gap between rises if <= PMAX.
    always @(posedge clk) begin
        in_rst = rst;
        if (rst) begin
            k = 0;
            lvl.delete();
            win_cnt   = 0;
            have_prev = 0;
            ns_exp    = 0;
            fq.delete();
            pq.delete();
        end else begin
            lvl.push_back(sig);
            r_m = (k >= 2) && lvl[k-2] && (k < 3 || !lvl[k-3]);
            if (r_m) win_cnt++;
            if (k % G == G - 1) begin
                fq.push_back('{k, (win_cnt > FMAX) ? FMAX : win_cnt});
                win_cnt = 0;
            end
            if (r_m) begin
                if (have_prev && (k - prev_rise) <= PMAX) begin
                    pq.push_back('{k, k - prev_rise});
                    ns_exp = 0;
                end
                prev_rise = k;
                have_prev = 1;
            end else if (have_prev && (k - prev_rise) == PMAX) begin
                ns_exp = 1;
            end
            k++;
        end
    end

    always @(negedge clk) begin
        if (in_rst) begin
            chk("rst_freq_hz", longint'(freq_hz), 0);
            chk("rst_freq_valid", longint'(freq_valid), 0);
            chk("rst_period_cycles", longint'(period_cycles), 0);
            chk("rst_period_valid", longint'(period_valid), 0);
            chk("rst_no_signal", longint'(no_signal), 0);
        end else begin
            if (freq_valid) begin
                chk("freq_expected", longint'(fq.size() > 0), 1);
                if (fq.size() > 0) begin
                    e = fq.pop_front();
                    chk("freq_timing", longint'(k - 1), longint'(e.idx));
                    chk("freq_hz", longint'(freq_hz), longint'(e.val));
                end
            end
            if (period_valid) begin
                chk("period_expected", longint'(pq.size() > 0), 1);
                if (pq.size() > 0) begin
                    e = pq.pop_front();
                    chk("period_timing", longint'(k - 1), longint'(e.idx));
                    chk("period_cycles", longint'(period_cycles), longint'(e.val));
                end
            end
            chk("no_signal", longint'(no_signal), longint'(ns_exp));
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input int hi, input int lo);
        sig = 1'b1;
        wait_cyc(hi);
        sig = 1'b0;
        wait_cyc(lo);
    endtask

    task automatic tone(input int per, input int n);
        repeat (n) pulse(per / 2, per - per / 2);
    endtask

    initial begin
        rst = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            sig = ~sig;
        end
        sig = 1'b0;
        rst = 1'b0;

        tone(100, 30);

        // Rise landing on gate count 999.
        sig = 1'b0;
        wait_cyc(3);
        while (k % G != 997) wait_cyc(1);
        sig = 1'b1;
        wait_cyc(5);
        sig = 1'b0;
        wait_cyc(5);
        tone(100, 5);

        tone(50, 6);
        sig = 1'b0;
        wait_cyc(400);
        tone(40, 4);

        tone(20, 150);

        tone(60, 10);
        sig = 1'b1;
        wait_cyc(10);
        rst = 1'b1;
        wait_cyc(3);
        rst = 1'b0;
        sig = 1'b0;
        wait_cyc(20);
        tone(70, 8);

        repeat (60) pulse(int'($urandom_range(2, 150)), int'($urandom_range(2, 150)));

        sig = 1'b0;
        wait_cyc(G + 300);
        @(negedge clk);
        #1;
        chk("freq_left_pending", longint'(fq.size()), 0);
        chk("period_left_pending", longint'(pq.size()), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
